uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   Serial UART receiver, the receive-side counterpart of the team's UART transmitter.
//   Frame format is 8N1: one low start bit, DATA_BITS data bits LSB first, one high stop bit.
//   A fixed number of clk cycles per bit sets the bit rate; there is no fractional baud.
//   The block samples each bit at mid-bit and presents a parallel byte with a 1-cycle valid strobe.
//   It sits between the rx pad and the host logic and has no back-pressure.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit; legal range 4..65535.
//   DATA_BITS     8   data bits per frame; legal range 5..8.
// PORTS
//   clk          in   1          system clock; all logic is on the rising edge.
//   reset        in   1          synchronous, active-high reset.
//   rx           in   1          asynchronous serial line; idles high.
//   data_out     out  DATA_BITS  last correctly framed byte; holds until the next good frame.
//   data_valid   out  1          1-cycle pulse; data_out is new in that same cycle.
//   frame_err    out  1          1-cycle pulse; the stop bit was sampled low.
//   busy         out  1          high whenever the FSM is not in IDLE.
// BEHAVIOUR
//   Reset values: data_out=0, data_valid=0, frame_err=0, busy=0.
//     Internal reset values: FSM=IDLE, counters=0, both sync flops=1.
//   Reset mid-frame aborts the frame with no pulse and leaves data_out at 0.
//   Input path
//     - rx passes through a 2-flop synchronizer (rx_s) before any use.
//     - No other filtering is applied.
//   Bit-cycle counter cnt
//     - Width $clog2(CLKS_PER_BIT).
//     - Cleared on every state change; otherwise increments each clk.
//   FSM states
//     IDLE: rx_s==0 -> START, cnt=0.
//     START: at cnt==CLKS_PER_BIT/2-1, sample rx_s.
//       - 0: go to DATA, bit index=0.
//       - 1: glitch; go to IDLE with no pulse.
//     DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register.
//       - The shift is right-shift, so the first bit received ends up as the LSB.
//       - After DATA_BITS samples go to STOP.
//     STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
//       - 1: data_out<=shift, data_valid=1 for one cycle, go to IDLE.
//       - 0: frame_err=1 for one cycle, data_out unchanged, go to BREAK.
//     BREAK: stay until rx_s==1, then go to IDLE.
//       - A held-low line (break) therefore yields exactly one frame_err.
//       - It does not retrigger new frames.
//   Pulse rules
//     - data_valid and frame_err are never high together.
//     - Each is registered and lasts exactly one cycle.
//   Timing
//     - busy rises the cycle after IDLE->START.
//     - The mid-bit sample points stay fixed relative to the detected start edge.
//     - Total latency from the rx fall to the data_valid pulse is 3 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles.
//     - With the default parameters this is 155 clks.
//   Back-to-back frames
//     - A new start edge is accepted in the first IDLE cycle after STOP.
//     - No idle gap is required beyond the stop bit.
//   Overrun: none is possible; the consumer must take data_out within one frame time.
// TESTING
//   Use defaults CLKS_PER_BIT=16, DATA_BITS=8; the bench tx drives exactly 16 clks per bit.
//   1. Reset held, then rx=1 idle for 100 clks.
//      -> All outputs stay 0 and busy stays 0.
//   2. Send 0xA5 8N1.
//      -> data_out=0xA5.
//      -> data_valid pulses once, 155 +/-1 clks after the rx fall.
//      -> frame_err stays 0.
//   3. Send 0x00 then 0xFF back-to-back with no idle gap.
//      -> Two data_valid pulses, 160 clks apart.
//      -> data_out=0x00, then 0xFF.
//   4. Pulse rx low for 4 clks only.
//      -> FSM returns to IDLE, with no data_valid and no frame_err.
//      -> A following 0x3C is received correctly.
//   5. Send 0x55 with the stop bit low, then hold rx low for 400 clks.
//      -> frame_err pulses exactly once.
//      -> data_out keeps its previous value and no data_valid occurs.
//      -> After rx returns high, a following 0x81 is received.
//   6. Assert reset during data bit 4 of a frame.
//      -> busy=0 the next cycle, and no pulse is produced.
//      -> The next full frame, 0xC3, is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized rx, mid-bit sampling with a fixed
// clk count per bit, parallel byte out with one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_meta;
  logic                 rx_s;

  // Single FSM: the counter free-runs and is cleared on every state change or bit sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (cnt == FULL_CNT) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (cnt == FULL_CNT) begin
            cnt <= '0;
            if (rx_s) begin
              data_out   <= shift;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end
        end
        BRK: begin
          // A held-low line must return high before another start edge is looked for.
          if (rx_s) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
